// File: rtl/chan_mix.sv
// chan_mix: per-channel sample fetch, linear interpolation, volume scaling
// and stereo accumulation, published once per sync period.
//
// Sample memory handshake: smp_req rises with smp_addr valid and both stay
// stable until the cycle smp_ack is high, in which smp_data is taken. The
// request then drops for at least one cycle before the next fetch.
module chan_mix #(
  parameter int ACC_W = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_stb_addr,
  input  logic        in_stb_mix,
  input  logic        sync_stb,
  output logic [21:0] smp_addr,
  output logic        smp_req,
  input  logic        smp_ack,
  input  logic [7:0]  smp_data,
  output logic [15:0] out_l,
  output logic [15:0] out_r,
  output logic        out_stb,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH0, S_FETCH1, S_INTERP, S_MULL, S_MULR
  } state_t;

  // Volume uses the low 7 bits; anything above unity (64) is held at 64.
  function automatic logic [6:0] clamp_vol(input logic [6:0] v);
    clamp_vol = (v > 7'd64) ? 7'd64 : v;
  endfunction

  // Capture registers (record being assembled)
  logic [2:0]  r_idx;
  logic [5:0]  r_addrhi;
  logic [7:0]  r_addrmid;
  logic [7:0]  r_addrlo;
  logic [7:0]  r_frac;
  logic [6:0]  r_vl;

  // Job registers
  state_t      r_state;
  logic [7:0]  r_job_frac;
  logic [6:0]  r_job_vl;
  logic [6:0]  r_job_vr;
  logic [21:0] r_smp_addr;
  logic        r_smp_req;
  logic [7:0]  r_s0;
  logic [7:0]  r_s1;
  logic [7:0]  r_s;
  logic signed [ACC_W-1:0] r_acc_l;
  logic signed [ACC_W-1:0] r_acc_r;
  logic [15:0] r_out_l;
  logic [15:0] r_out_r;
  logic        r_out_stb;
  logic        r_overrun;

  logic        w_complete;
  logic [21:0] w_rec_addr;
  logic signed [16:0] w_s0x;
  logic signed [16:0] w_s1x;
  logic signed [16:0] w_diff;
  logic signed [16:0] w_fracx;
  logic signed [16:0] w_iprod;
  logic        w_unused_ip_hi;
  logic [7:0]  w_ip_mid;
  logic [7:0]  w_unused_ip_lo;
  logic [7:0]  w_s_next;
  logic signed [14:0] w_sx;
  logic signed [14:0] w_volx;
  logic signed [14:0] w_mprod;
  logic signed [ACC_W-1:0] w_term;
  logic signed [ACC_W-1:0] w_add_l;
  logic signed [ACC_W-1:0] w_add_r;

  // The vr byte completes a record; addr strobes take priority.
  assign w_complete = in_stb_mix && !in_stb_addr && (r_idx == 3'd5);
  assign w_rec_addr = {r_addrhi, r_addrmid, r_addrlo};

  // Interpolation: s0 + ((s1 - s0) * frac) >>> 8. Bits [15:8] of the product
  // are the shifted term; adding it modulo 256 gives the exact 8-bit result.
  assign w_s0x   = {{9{r_s0[7]}}, r_s0};
  assign w_s1x   = {{9{r_s1[7]}}, r_s1};
  assign w_diff  = w_s1x - w_s0x;
  assign w_fracx = {9'd0, r_job_frac};
  assign w_iprod = w_diff * w_fracx;
  assign {w_unused_ip_hi, w_ip_mid, w_unused_ip_lo} = w_iprod;
  assign w_s_next = r_s0 + w_ip_mid;

  // One multiplier serves both volume products.
  assign w_sx    = {{7{r_s[7]}}, r_s};
  assign w_volx  = {8'd0, (r_state == S_MULL) ? r_job_vl : r_job_vr};
  assign w_mprod = w_sx * w_volx;
  assign w_term  = {{(ACC_W-15){w_mprod[14]}}, w_mprod};
  assign w_add_l = (r_state == S_MULL) ? w_term : '0;
  assign w_add_r = (r_state == S_MULR) ? w_term : '0;

  // Capture the 6-byte parameter stream into the record registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx     <= 3'd0;
      r_addrhi  <= 6'd0;
      r_addrmid <= 8'd0;
      r_addrlo  <= 8'd0;
      r_frac    <= 8'd0;
      r_vl      <= 7'd0;
    end else if (in_stb_addr) begin
      if (r_idx <= 3'd2) begin
        case (r_idx)
          3'd0:    r_addrhi  <= in_data[5:0];
          3'd1:    r_addrmid <= in_data;
          default: r_addrlo  <= in_data;
        endcase
        r_idx <= r_idx + 3'd1;
      end else begin
        r_addrhi <= in_data[5:0];
        r_idx    <= 3'd1;
      end
    end else if (in_stb_mix && (r_idx >= 3'd3)) begin
      case (r_idx)
        3'd3:    r_frac <= in_data;
        3'd4:    r_vl   <= clamp_vol(in_data[6:0]);
        default: ;
      endcase
      r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
    end
  end

  // Job engine, accumulators and period publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_job_frac <= 8'd0;
      r_job_vl   <= 7'd0;
      r_job_vr   <= 7'd0;
      r_smp_addr <= 22'd0;
      r_smp_req  <= 1'b0;
      r_s0       <= 8'd0;
      r_s1       <= 8'd0;
      r_s        <= 8'd0;
      r_acc_l    <= '0;
      r_acc_r    <= '0;
      r_out_l    <= 16'd0;
      r_out_r    <= 16'd0;
      r_out_stb  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_out_stb <= sync_stb;
      if (w_complete && (r_state != S_IDLE)) r_overrun <= 1'b1;

      // A sync publishes the pre-add value; a coincident add opens the new period.
      if (sync_stb) begin
        r_out_l <= r_acc_l[18:3];
        r_out_r <= r_acc_r[18:3];
        r_acc_l <= w_add_l;
        r_acc_r <= w_add_r;
      end else begin
        r_acc_l <= r_acc_l + w_add_l;
        r_acc_r <= r_acc_r + w_add_r;
      end

      case (r_state)
        S_IDLE: begin
          if (w_complete) begin
            r_job_frac <= r_frac;
            r_job_vl   <= r_vl;
            r_job_vr   <= clamp_vol(in_data[6:0]);
            r_smp_addr <= w_rec_addr;
            r_smp_req  <= 1'b1;
            r_state    <= S_FETCH0;
          end
        end
        S_FETCH0: begin
          if (smp_ack) begin
            r_s0       <= smp_data;
            r_smp_req  <= 1'b0;
            r_smp_addr <= r_smp_addr + 22'd1;
            r_state    <= S_FETCH1;
          end
        end
        S_FETCH1: begin
          if (!r_smp_req) begin
            r_smp_req <= 1'b1;
          end else if (smp_ack) begin
            r_s1      <= smp_data;
            r_smp_req <= 1'b0;
            r_state   <= S_INTERP;
          end
        end
        S_INTERP: begin
          r_s     <= w_s_next;
          r_state <= S_MULL;
        end
        S_MULL:  r_state <= S_MULR;
        S_MULR:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign smp_addr = r_smp_addr;
  assign smp_req  = r_smp_req;
  assign out_l    = r_out_l;
  assign out_r    = r_out_r;
  assign out_stb  = r_out_stb;
  assign busy     = (r_state != S_IDLE);
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_chan_mix.sv
// Bench for chan_mix: directed records against a sparse sample memory, a
// behavioural mixing model feeding an expected queue, and literal pins.
module tb_chan_mix;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'd0;
  logic        in_stb_addr = 1'b0;
  logic        in_stb_mix = 1'b0;
  logic        sync_stb = 1'b0;
  logic [21:0] smp_addr;
  logic        smp_req;
  logic        smp_ack = 1'b0;
  logic [7:0]  smp_data = 8'd0;
  logic [15:0] out_l;
  logic [15:0] out_r;
  logic        out_stb;
  logic        busy;
  logic        overrun;

  always #5 clk = ~clk;

  chan_mix #(.ACC_W(20)) dut (
    .clk(clk), .rst(rst), .in_data(in_data),
    .in_stb_addr(in_stb_addr), .in_stb_mix(in_stb_mix), .sync_stb(sync_stb),
    .smp_addr(smp_addr), .smp_req(smp_req), .smp_ack(smp_ack), .smp_data(smp_data),
    .out_l(out_l), .out_r(out_r), .out_stb(out_stb), .busy(busy), .overrun(overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- sample memory model ----------------
  logic [7:0]  mem [int];
  int          ack_delay = 0;
  bit          hold_ack = 1'b0;
  int          ack_count = 0;
  logic [21:0] addr_log[$];
  bit          seen = 1'b0;
  bit          acked = 1'b0;
  bit          prev_ack = 1'b0;
  int          wait_cnt = 0;
  logic [21:0] held_addr = 22'd0;

  function automatic logic [7:0] mem_rd(input logic [21:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return 8'h00;
  endfunction

  // Responds to requests; also checks address stability and the request gap.
  always @(negedge clk) begin
    if (prev_ack) begin
      n_checks++;
      if (smp_req !== 1'b0) begin
        n_errors++;
        $display("FAIL req_gap: smp_req=%b after ack, expected 0", smp_req);
      end
    end
    prev_ack = 1'b0;
    smp_ack  = 1'b0;
    if (rst || !smp_req) begin
      seen = 1'b0; acked = 1'b0; wait_cnt = 0;
    end else if (!acked) begin
      if (!seen) begin
        seen = 1'b1; held_addr = smp_addr;
      end else begin
        n_checks++;
        if (smp_addr !== held_addr) begin
          n_errors++;
          $display("FAIL addr_hold: smp_addr=%h expected %h", smp_addr, held_addr);
        end
      end
      if (!hold_ack) begin
        if (wait_cnt >= ack_delay) begin
          smp_ack  = 1'b1;
          smp_data = mem_rd(smp_addr);
          acked    = 1'b1;
          prev_ack = 1'b1;
          ack_count++;
          addr_log.push_back(smp_addr);
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // ---------------- behavioural mixing model ----------------
  int acc_l = 0, acc_r = 0, pend_l = 0, pend_r = 0;
  logic [31:0] exp_q[$];

  function automatic int sbyte(input logic [7:0] b);
    logic signed [7:0] t;
    t = b;
    return int'(t);
  endfunction

  function automatic int vol_of(input logic [7:0] v);
    int x;
    x = int'(v & 8'h7F);
    if (x > 64) x = 64;
    return x;
  endfunction

  function automatic logic [15:0] pub(input int acc);
    int t;
    t = acc >>> 3;
    return t[15:0];
  endfunction

  task automatic model_add(input logic [7:0] hi, mid, lo, fr, l, r);
    logic [21:0] a;
    int s0, s1, s;
    a  = {hi[5:0], mid, lo};
    s0 = sbyte(mem_rd(a));
    s1 = sbyte(mem_rd(a + 22'd1));
    s  = s0 + (((s1 - s0) * int'(fr)) >>> 8);
    pend_l += s * vol_of(l);
    pend_r += s * vol_of(r);
  endtask

  task automatic commit();
    acc_l += pend_l; acc_r += pend_r;
    pend_l = 0; pend_r = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic put_byte(input bit is_addr, input logic [7:0] d);
    @(negedge clk);
    in_data = d; in_stb_addr = is_addr; in_stb_mix = !is_addr;
    @(negedge clk);
    in_stb_addr = 1'b0; in_stb_mix = 1'b0;
  endtask

  task automatic send_record(input logic [7:0] hi, mid, lo, fr, l, r, input bit accept);
    put_byte(1'b1, hi); put_byte(1'b1, mid); put_byte(1'b1, lo);
    put_byte(1'b0, fr); put_byte(1'b0, l);   put_byte(1'b0, r);
    if (accept) model_add(hi, mid, lo, fr, l, r);
  endtask

  task automatic do_sync();
    @(negedge clk);
    sync_stb = 1'b1;
    exp_q.push_back({pub(acc_l), pub(acc_r)});
    acc_l = 0; acc_r = 0;
    @(negedge clk);
    sync_stb = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("idle_reached", ok, 1);
  endtask

  task automatic wait_out(input logic [15:0] el, input logic [15:0] er);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_stb) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("out_stb_seen", got, 1);
    if (got) begin
      check("out_l_literal", out_l, el);
      check("out_r_literal", out_r, er);
      @(negedge clk);
      check("out_stb_one_cycle", out_stb, 0);
    end
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (!rst && out_stb) begin
      logic [31:0] e;
      if (exp_q.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL out_stb_unexpected: out_l=%h out_r=%h with no expected entry", out_l, out_r);
      end else begin
        e = exp_q.pop_front();
        check("model_out_lr", {out_l, out_r}, e);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int start;

    repeat (3) @(negedge clk);
    check("rst_out_l", out_l, 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_stb", out_stb, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_smp_req", smp_req, 0);
    check("rst_smp_addr", smp_addr, 0);
    rst = 1'b0;

    // Basic single channel
    mem[32'h012345] = 8'h10; mem[32'h012346] = 8'h20;
    addr_log.delete();
    send_record(8'h01, 8'h23, 8'h45, 8'h00, 8'd64, 8'd32, 1'b1);
    wait_idle(); commit();
    check("basic_fetch_count", addr_log.size(), 2);
    if (addr_log.size() >= 2) begin
      check("basic_fetch0", addr_log[0], 22'h012345);
      check("basic_fetch1", addr_log[1], 22'h012346);
    end
    do_sync();
    wait_out(16'h0080, 16'h0040);

    // Interpolation across full range
    mem[32'h000100] = 8'h80; mem[32'h000101] = 8'h7F;
    send_record(8'h00, 8'h01, 8'h00, 8'h80, 8'd64, 8'd64, 1'b1);
    wait_idle(); commit();
    do_sync();
    wait_out(16'hFFF8, 16'hFFF8);

    // Address wrap and volume clamp
    mem[32'h3FFFFF] = 8'h05; mem[32'h000000] = 8'h15;
    addr_log.delete();
    send_record(8'hFF, 8'hFF, 8'hFF, 8'h40, 8'h7F, 8'h10, 1'b1);
    wait_idle(); commit();
    check("wrap_fetch_count", addr_log.size(), 2);
    if (addr_log.size() >= 2) begin
      check("wrap_fetch0", addr_log[0], 22'h3FFFFF);
      check("wrap_fetch1", addr_log[1], 22'h000000);
    end
    do_sync();
    wait_out(16'h0048, 16'h0012);

    // Full scale: 32 channels at -128, unity volume, slow memory
    ack_delay = 3;
    mem[32'h000200] = 8'h80; mem[32'h000201] = 8'h80;
    for (int i = 0; i < 32; i++) begin
      send_record(8'h00, 8'h02, 8'h00, 8'h00, 8'd64, 8'd0, 1'b1);
      wait_idle(); commit();
    end
    do_sync();
    wait_out(16'h8000, 16'h0000);
    check("fullscale_no_overrun", overrun, 0);
    ack_delay = 0;

    // Overrun: second record arrives while the first is stalled
    mem[32'h000300] = 8'h20; mem[32'h000400] = 8'h7F;
    addr_log.delete();
    hold_ack = 1'b1;
    send_record(8'h00, 8'h03, 8'h00, 8'h00, 8'd64, 8'd64, 1'b1);
    send_record(8'h00, 8'h04, 8'h00, 8'h00, 8'd64, 8'd64, 1'b0);
    check("overrun_set", overrun, 1);
    hold_ack = 1'b0;
    wait_idle(); commit();
    check("overrun_fetch_count", addr_log.size(), 2);
    do_sync();
    wait_out(16'h0100, 16'h0100);
    check("overrun_sticky", overrun, 1);

    // Capture sequencing: stray mix byte, then restart at idx 4
    mem[32'h000500] = 8'h7F;
    addr_log.delete();
    put_byte(1'b0, 8'h55);
    put_byte(1'b1, 8'h00); put_byte(1'b1, 8'h04); put_byte(1'b1, 8'h00);
    put_byte(1'b0, 8'h00);
    check("partial_no_launch", busy, 0);
    send_record(8'h00, 8'h05, 8'h00, 8'h00, 8'd1, 8'd64, 1'b1);
    wait_idle(); commit();
    check("restart_fetch_count", addr_log.size(), 2);
    if (addr_log.size() >= 1) check("restart_fetch0", addr_log[0], 22'h000500);
    do_sync();
    wait_out(16'h000F, 16'h03F8);

    // Sync landing on the MULL cycle: channel moves to the next period
    mem[32'h000600] = 8'h10; mem[32'h000601] = 8'h10;
    start = ack_count;
    send_record(8'h00, 8'h06, 8'h00, 8'h00, 8'd64, 8'd64, 1'b1);
    for (int i = 0; i < 100; i++) begin
      if (ack_count >= start + 2) break;
      @(negedge clk);
      #1;
    end
    check("collision_second_ack", (ack_count >= start + 2), 1);
    @(negedge clk);
    do_sync();
    wait_out(16'h0000, 16'h0000);
    wait_idle(); commit();
    do_sync();
    wait_out(16'h0080, 16'h0080);

    // Reset during FETCH1 with a non-empty accumulator
    mem[32'h000700] = 8'h40; mem[32'h000701] = 8'h40;
    send_record(8'h00, 8'h07, 8'h00, 8'h00, 8'd64, 8'd64, 1'b1);
    wait_idle(); commit();
    start = ack_count;
    send_record(8'h00, 8'h07, 8'h00, 8'h00, 8'd64, 8'd64, 1'b0);
    #1;
    for (int i = 0; i < 20; i++) begin
      if (ack_count >= start + 1) break;
      @(negedge clk);
      #1;
    end
    hold_ack = 1'b1;
    repeat (2) @(negedge clk);
    check("fetch1_req_pending", smp_req, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_smp_req", smp_req, 0);
    check("midrst_smp_addr", smp_addr, 0);
    check("midrst_out_l", out_l, 0);
    check("midrst_out_r", out_r, 0);
    check("midrst_out_stb", out_stb, 0);
    check("midrst_busy", busy, 0);
    check("midrst_overrun", overrun, 0);
    rst = 1'b0;
    hold_ack = 1'b0;
    acc_l = 0; acc_r = 0; pend_l = 0; pend_r = 0;
    do_sync();
    wait_out(16'h0000, 16'h0000);

    repeat (3) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
